uart_rx_ctrl: RTL
=================

UART_RX_CTRL -- requirements
Module: uart_rx_ctrl

Interface
REQ-001 SHALL have parameter CLK_DIV_W, default 16, width of the baud divisor.
REQ-002 SHALL have port clk_i  in  1  sole clock, all logic on rising edge.
REQ-003 SHALL have port srst_i  in  1  synchronous, active-high reset.
REQ-004 SHALL have port rx_i  in  1  serial line, already synchronised to clk_i, idle high.
REQ-005 SHALL have port clk_div_i  in  CLK_DIV_W  clk_i cycles per bit; values below 4 treated as 4.
REQ-006 SHALL have port parity_en_i  in  1  parity bit present after DATA_7.
REQ-007 SHALL have port parity_odd_i  in  1  1=odd parity, 0=even parity.
REQ-008 SHALL have port data_o  out  8  last received byte.
REQ-009 SHALL have port data_valid_o  out  1  data_o/flags valid, held until data_ready_i.
REQ-010 SHALL have port data_ready_i  in  1  consumer accepts data_o.
REQ-011 SHALL have port parity_err_o  out  1  parity mismatch on frame in data_o.
REQ-012 SHALL have port frame_err_o  out  1  stop bit sampled low on frame in data_o.
REQ-013 SHALL have port overrun_o  out  1  one-cycle pulse: completed frame overwrote unaccepted data.
REQ-014 SHALL have port state_o  out  uart_rx_state_e  current frame state.

Function
REQ-015 States SHALL be IDLE, START_BIT, DATA_0..DATA_7, PARITY_BIT, STOP_BIT.
REQ-016 rx_q SHALL register rx_i each cycle; start edge = rx_q==1 and rx_i==0 while in IDLE -> START_BIT, bit counter cleared.
REQ-017 Outside IDLE, the bit counter SHALL increment each cycle; tick when counter == limit, then counter returns to 0.
REQ-018 Limit SHALL be (div>>1)-1 in START_BIT (mid-start sample), div-1 in all other states (div = clamped clk_div_i).
REQ-019 START_BIT tick: rx_i==1 -> false start, return to IDLE, no output change; rx_i==0 -> DATA_0.
REQ-020 DATA_n tick: shift register bit n <= rx_i (LSB first); DATA_n -> DATA_n+1; DATA_7 -> PARITY_BIT if parity_en_i else STOP_BIT.
REQ-021 PARITY_BIT tick: store parity error = (XOR of data bits ^ rx_i) != parity_odd_i; -> STOP_BIT.
REQ-022 STOP_BIT tick: next cycle data_o, parity_err_o (0 if parity disabled), frame_err_o = ~rx_i, data_valid_o=1; state -> IDLE in same tick.
REQ-023 parity_en_i and clk_div_i SHALL be sampled at start edge and held for the frame; mid-frame changes have no effect.
REQ-024 data_valid_o SHALL drop on the cycle after data_valid_o & data_ready_i, unless a frame completes that same cycle.
REQ-025 Frame completion with data_valid_o=1 and data_ready_i=0: data overwritten, data_valid_o stays 1, overrun_o pulses 1 cycle.
REQ-026 Frame completion coincident with data_valid_o & data_ready_i: new data loaded, data_valid_o stays 1, no overrun.
REQ-027 Latency: data_valid_o SHALL rise 1 + div/2 + (9 + parity_en)*div cycles after first cycle rx_i sampled low.

Reset
REQ-028 srst_i SHALL, on any clock edge including mid-frame, force state IDLE, counter 0, rx_q 1, shift register 0.
REQ-029 After reset: data_o=0, data_valid_o=0, parity_err_o=0, frame_err_o=0, overrun_o=0, state_o=IDLE.
REQ-030 srst_i SHALL take priority over all other inputs, including data_ready_i and a coincident start edge.

Structure
REQ-031 uart_rx_state_e SHALL come from the shared uart_rx_pkg; the minimum divisor constant (4) SHALL be added there.
REQ-032 Bit timing SHALL be one sub-module, uart_rx_bit_timer (clear, limit, tick out); everything else in uart_rx_ctrl.

Verification
REQ-033 div=16, no parity, byte 0xA5, stop high -> data_o=0xA5, data_valid_o high 153 cycles after first low sample, both errors 0.
REQ-034 div=16, even parity, byte 0x03, parity bit 1 -> parity_err_o=1; same with parity bit 0 -> parity_err_o=0.
REQ-035 div=8, 3-cycle low glitch on rx_i -> returns to IDLE after 4 cycles, data_valid_o stays 0.
REQ-036 div=16, byte 0x55, stop bit low -> frame_err_o=1, data_o=0x55.
REQ-037 Two back-to-back frames 0x11, 0x22, data_ready_i=0 -> overrun_o one pulse, data_o=0x22; ready=1 next cycle -> data_valid_o=0.
REQ-038 srst_i asserted during DATA_4 -> next cycle state_o=IDLE, all outputs 0; following frame 0x3C received correctly.

Source files
------------

// File: rtl/uart_rx_pkg.sv
// Shared UART receiver types: frame states, minimum bit divisor, data-state helper.
package uart_rx_pkg;

  typedef enum logic [3:0] {
    IDLE       = 4'd0,
    START_BIT  = 4'd1,
    DATA_0     = 4'd2,
    DATA_1     = 4'd3,
    DATA_2     = 4'd4,
    DATA_3     = 4'd5,
    DATA_4     = 4'd6,
    DATA_5     = 4'd7,
    DATA_6     = 4'd8,
    DATA_7     = 4'd9,
    PARITY_BIT = 4'd10,
    STOP_BIT   = 4'd11
  } uart_rx_state_e;

  localparam int unsigned UART_RX_MIN_DIV = 4;

  // Bit position written while in DATA_n; only meaningful for the data states.
  function automatic logic [2:0] data_bit_idx(input uart_rx_state_e s);
    return 3'(4'(s) - 4'(DATA_0));
  endfunction

endpackage

// File: rtl/uart_rx_bit_timer.sv
// Bit-period counter: held at zero while cleared, otherwise counts up and pulses tick_o
// combinationally when the count equals limit_i, wrapping to zero on that cycle.
module uart_rx_bit_timer #(
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             srst_i,
  input  logic             clr_i,
  input  logic [CNT_W-1:0] limit_i,
  output logic             tick_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    tick_o = !clr_i && (cnt_q == limit_i);
    cnt_d  = cnt_q + CNT_W'(1);
    if (clr_i || tick_o) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receiver: 8N1 / 8E1 / 8O1 framing, byte held with valid until accepted.
// A frame completing on unaccepted data overwrites it and pulses overrun_o.
module uart_rx_ctrl
  import uart_rx_pkg::*;
#(
  parameter int CLK_DIV_W = 16
) (
  input  logic                 clk_i,
  input  logic                 srst_i,
  input  logic                 rx_i,
  input  logic [CLK_DIV_W-1:0] clk_div_i,
  input  logic                 parity_en_i,
  input  logic                 parity_odd_i,
  output logic [7:0]           data_o,
  output logic                 data_valid_o,
  input  logic                 data_ready_i,
  output logic                 parity_err_o,
  output logic                 frame_err_o,
  output logic                 overrun_o,
  output uart_rx_state_e       state_o
);

  localparam logic [CLK_DIV_W-1:0] MIN_DIV = CLK_DIV_W'(UART_RX_MIN_DIV);

  uart_rx_state_e       state_q, state_d;
  logic                 rx_q;
  logic [7:0]           shift_q, shift_d;
  logic [CLK_DIV_W-1:0] div_q, div_d;
  logic                 par_en_q, par_en_d;
  logic                 par_err_q, par_err_d;
  logic [7:0]           data_q, data_d;
  logic                 vld_q, vld_d;
  logic                 perr_q, perr_d;
  logic                 ferr_q, ferr_d;
  logic                 ovr_q, ovr_d;

  logic                 tick;
  logic                 start_edge;
  logic [CLK_DIV_W-1:0] div_clamped;
  logic [CLK_DIV_W-1:0] limit;

  assign div_clamped = (clk_div_i < MIN_DIV) ? MIN_DIV : clk_div_i;
  assign start_edge  = (state_q == IDLE) && rx_q && !rx_i;
  // Half period in START_BIT so every later tick lands near mid-bit.
  assign limit       = (state_q == START_BIT) ? (div_q >> 1) - CLK_DIV_W'(1)
                                              : div_q - CLK_DIV_W'(1);

  uart_rx_bit_timer #(.CNT_W(CLK_DIV_W)) u_bit_timer (
    .clk_i   (clk_i),
    .srst_i  (srst_i),
    .clr_i   (state_q == IDLE),
    .limit_i (limit),
    .tick_o  (tick)
  );

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    div_d     = div_q;
    par_en_d  = par_en_q;
    par_err_d = par_err_q;
    data_d    = data_q;
    perr_d    = perr_q;
    ferr_d    = ferr_q;
    ovr_d     = 1'b0;
    vld_d     = vld_q && !data_ready_i;

    case (state_q)
      IDLE: begin
        if (start_edge) begin
          state_d   = START_BIT;
          div_d     = div_clamped;
          par_en_d  = parity_en_i;
          par_err_d = 1'b0;
        end
      end
      START_BIT: begin
        if (tick) begin
          state_d = rx_i ? IDLE : DATA_0;
        end
      end
      PARITY_BIT: begin
        if (tick) begin
          par_err_d = ((^shift_q) ^ rx_i) != parity_odd_i;
          state_d   = STOP_BIT;
        end
      end
      STOP_BIT: begin
        if (tick) begin
          state_d = IDLE;
          data_d  = shift_q;
          perr_d  = par_en_q && par_err_q;
          ferr_d  = !rx_i;
          vld_d   = 1'b1;
          ovr_d   = vld_q && !data_ready_i;
        end
      end
      default: begin
        if (tick) begin
          shift_d[data_bit_idx(state_q)] = rx_i;
          if (state_q == DATA_7) begin
            state_d = par_en_q ? PARITY_BIT : STOP_BIT;
          end else begin
            state_d = uart_rx_state_e'(4'(state_q) + 4'd1);
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      state_q   <= IDLE;
      rx_q      <= 1'b1;
      shift_q   <= '0;
      div_q     <= MIN_DIV;
      par_en_q  <= 1'b0;
      par_err_q <= 1'b0;
      data_q    <= '0;
      vld_q     <= 1'b0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      rx_q      <= rx_i;
      shift_q   <= shift_d;
      div_q     <= div_d;
      par_en_q  <= par_en_d;
      par_err_q <= par_err_d;
      data_q    <= data_d;
      vld_q     <= vld_d;
      perr_q    <= perr_d;
      ferr_q    <= ferr_d;
      ovr_q     <= ovr_d;
    end
  end

  assign data_o       = data_q;
  assign data_valid_o = vld_q;
  assign parity_err_o = perr_q;
  assign frame_err_o  = ferr_q;
  assign overrun_o    = ovr_q;
  assign state_o      = state_q;

endmodule
